regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-port register file; the next generation of the CPU's 16 × 18-bit register file. Generalises data width, depth and number of read ports. Adds:
- a second write port;
- synchronous read outputs with per-port valid flags;
- optional write-to-read bypass;
- optional hardwired-zero register 0.

It sits between the decode stage, which supplies the read addresses, and the ALU/writeback paths, which supply up to two writes per cycle.

## Interface
- DATA_WIDTH, 18, bits per register
- ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH registers
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes
- BYPASS, 1, 1 = a read returns data being written at the same edge

- Clk  in  1  clock, all state updates on rising edge
- Rst  in  1  asynchronous, active-high reset
- RdEn  in  NUM_RD  per-port read enable
- RdAddr  in  NUM_RD*ADDR_WIDTH  read addresses; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- RdData  out  NUM_RD*DATA_WIDTH  registered read data; port i at [i*DATA_WIDTH +: DATA_WIDTH]
- RdValid  out  NUM_RD  high for the cycle after an enabled read
- WrEn0, WrEn1  in  1  write enables, ports 0 and 1
- WrAddr0, WrAddr1  in  ADDR_WIDTH  write addresses
- WrData0, WrData1  in  DATA_WIDTH  write data

## Operation
- **Reset.** While Rst is high, all DEPTH registers, RdData and RdValid are 0. Takes effect immediately, independent of Clk. This includes a reset asserted mid-cycle or during an in-flight read.
- **Write.** At the rising edge, if WrEnk=1, the register at WrAddrk loads WrDatak.
- **Write collision.** If both write ports are enabled with WrAddr0 == WrAddr1, port 1 wins. The register holds WrData1. No error is flagged.
- **Hardwired zero.** With ZERO_REG=1, writes to address 0 are discarded and reads of address 0 return 0.
- **Read, enabled.** At the rising edge, for each port i with RdEn[i]=1:
  - the RdData slice for port i loads the register at the RdAddr slice for port i;
  - RdValid[i] is set to 1.
- **Read, disabled.** If RdEn[i]=0, the RdData slice for port i holds its previous value and RdValid[i] is set to 0.
- **Bypass on (BYPASS=1).** If a read address equals an enabled write address at the same edge, RdData gets the new data. Port 1 wins over port 0, consistent with the write-collision rule. The ZERO_REG rule overrides bypass.
- **Bypass off (BYPASS=0).** Under the same conditions, RdData gets the pre-write contents.
- **Multiple readers.** Any number of read ports may address the same register in one cycle. All see identical data.
- **Address range.** All ADDR_WIDTH-bit addresses are valid; no out-of-range case exists.

## Timing
- **Read latency.** 1 cycle: address and enable are sampled at edge t; RdData/RdValid are valid after edge t and stable until edge t+1.
- **Write latency.** Data written at edge t is visible to a read sampled at edge t+1. With BYPASS=1 it is also visible to a read sampled at edge t.
- **Throughput.** Every port accepts a new request every cycle; no stalls and no handshake backpressure.
- **Reset release.** The first edge with Rst low performs normal operation.

## Structure
- **Shared package `regfile_pkg`:**
  - default constants RF_DATA_WIDTH=18 and RF_ADDR_WIDTH=4;
  - a data-word typedef and an address typedef derived from them;
  - NUM_RD limit constant RF_MAX_RD=4.
- **Sub-module `regfile_rd_port`:**
  - one instance per read port, created with a generate loop;
  - each contains the array mux, the bypass/zero compare logic and the RdData/RdValid output register.
- **Top level** holds the storage array, the two write decoders with port-1 priority, and the generate loop.

## Test plan
- **Reset clears state.** Write 0x155 to r3, then assert Rst mid-cycle. RdData and RdValid go to 0 immediately; a read of r3 after release returns 0.
- **Basic write/read with latency.** Write 123 to r5 at edge t, then read r5 on port 1 at edge t+1. After edge t+1: RdData for port 1 = 123 and RdValid[1]=1. Drop RdEn: data holds at 123 and RdValid[1]=0.
- **Dual-write collision.** At one edge write WrAddr0=7/WrData0=0x00A and WrAddr1=7/WrData1=0x3FFFF. A later read of r7 returns 0x3FFFF.
- **Bypass, BYPASS=1.** r2=10. At the same edge, write 20 to r2 and read r2 on both ports. Both ports return 20.
- **No bypass, BYPASS=0.** Same stimulus as the bypass case: both ports return 10, and the next read returns 20.
- **Hardwired zero, ZERO_REG=1.** Write 0x2AAAA to r0, then read r0, also with bypass active in the same cycle. Both return 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and types for the multi-port register file
package regfile_pkg;

    localparam int RF_DATA_WIDTH = 18;
    localparam int RF_ADDR_WIDTH = 4;
    localparam int RF_MAX_RD     = 4;

    typedef logic [RF_DATA_WIDTH-1:0] rfData_t;
    typedef logic [RF_ADDR_WIDTH-1:0] rfAddr_t;

endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - read/write port bundle between decode/writeback and the register file
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int NUM_RD     = 2
);

    logic [NUM_RD-1:0]            RdEn;
    logic [NUM_RD*ADDR_WIDTH-1:0] RdAddr;
    logic [NUM_RD*DATA_WIDTH-1:0] RdData;
    logic [NUM_RD-1:0]            RdValid;
    logic                         WrEn0;
    logic                         WrEn1;
    logic [ADDR_WIDTH-1:0]        WrAddr0;
    logic [ADDR_WIDTH-1:0]        WrAddr1;
    logic [DATA_WIDTH-1:0]        WrData0;
    logic [DATA_WIDTH-1:0]        WrData1;

    modport master (
        output RdEn, RdAddr, WrEn0, WrEn1, WrAddr0, WrAddr1, WrData0, WrData1,
        input  RdData, RdValid
    );

    modport slave (
        input  RdEn, RdAddr, WrEn0, WrEn1, WrAddr0, WrAddr1, WrData0, WrData1,
        output RdData, RdValid
    );

endinterface

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one registered read port with bypass and hardwired-zero handling
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter bit ZERO_REG   = 1'b0,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                                       Clk,
    input  logic                                       Rst,
    input  logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0]   regs,
    input  logic                                       rdEn,
    input  logic [ADDR_WIDTH-1:0]                      rdAddr,
    input  logic                                       wrEn0,
    input  logic [ADDR_WIDTH-1:0]                      wrAddr0,
    input  logic [DATA_WIDTH-1:0]                      wrData0,
    input  logic                                       wrEn1,
    input  logic [ADDR_WIDTH-1:0]                      wrAddr1,
    input  logic [DATA_WIDTH-1:0]                      wrData1,
    output logic [DATA_WIDTH-1:0]                      rdData,
    output logic                                       rdValid
);

    logic [DATA_WIDTH-1:0] nextData;

    // Port 1 is checked first so bypass agrees with the write-collision winner.
    always_comb begin
        nextData = regs[rdAddr];
        if (BYPASS && wrEn1 && (wrAddr1 == rdAddr)) begin
            nextData = wrData1;
        end else if (BYPASS && wrEn0 && (wrAddr0 == rdAddr)) begin
            nextData = wrData0;
        end
        if (ZERO_REG && (rdAddr == '0)) begin
            nextData = '0;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rdData  <= '0;
            rdValid <= 1'b0;
        end else begin
            rdValid <= rdEn;
            if (rdEn) begin
                rdData <= nextData;
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised register file with two write ports and NUM_RD registered read ports
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int NUM_RD     = 2,
    parameter bit ZERO_REG   = 1'b0,
    parameter bit BYPASS     = 1'b1
) (
    input logic         Clk,
    input logic         Rst,
    regfile_mp_if.slave rf
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DEPTH-1:0][DATA_WIDTH-1:0]  regs;
    logic [DEPTH-1:0]                  wrSel0;
    logic [DEPTH-1:0]                  wrSel1;
    logic                              wrOk0;
    logic                              wrOk1;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0] rdDataArr;
    logic [NUM_RD-1:0]                 rdValidArr;

    assign wrOk0 = rf.WrEn0 && !(ZERO_REG && (rf.WrAddr0 == '0));
    assign wrOk1 = rf.WrEn1 && !(ZERO_REG && (rf.WrAddr1 == '0));

    always_comb begin
        wrSel0 = '0;
        wrSel1 = '0;
        if (wrOk0) begin
            wrSel0[rf.WrAddr0] = 1'b1;
        end
        if (wrOk1) begin
            wrSel1[rf.WrAddr1] = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            regs <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wrSel1[i]) begin
                    regs[i] <= rf.WrData1;
                end else if (wrSel0[i]) begin
                    regs[i] <= rf.WrData0;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : gRd
        regfile_rd_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .ZERO_REG   (ZERO_REG),
            .BYPASS     (BYPASS)
        ) uPort (
            .Clk     (Clk),
            .Rst     (Rst),
            .regs    (regs),
            .rdEn    (rf.RdEn[g]),
            .rdAddr  (rf.RdAddr[g*ADDR_WIDTH +: ADDR_WIDTH]),
            .wrEn0   (wrOk0),
            .wrAddr0 (rf.WrAddr0),
            .wrData0 (rf.WrData0),
            .wrEn1   (wrOk1),
            .wrAddr1 (rf.WrAddr1),
            .wrData1 (rf.WrData1),
            .rdData  (rdDataArr[g]),
            .rdValid (rdValidArr[g])
        );
    end

    assign rf.RdData  = rdDataArr;
    assign rf.RdValid = rdValidArr;

endmodule
